// File: rtl/register_chain_pkg.sv
// register_chain_pkg: mode encodings and the fill-count width helper shared by
// the register_chain top level and the bench.
`default_nettype none

package register_chain_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  localparam int c_MIN_DEPTH = 2;
  localparam int c_MAX_DEPTH = 16;

  // Width needed to hold a fill count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_chain_stage.sv
// chain_stage: one N-bit register of the chain, with a synchronous
// active-low reset to INI, a load enable and a data input.
`default_nettype none

module chain_stage #(
  parameter int             N   = 4,
  parameter logic [N-1:0]   INI = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= INI;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/register_chain.sv
// register_chain: DEPTH-stage N-bit shift/rotate register with a saturating
// fill counter. Define REGISTER_CHAIN_TAPS_EN to expose every stage on taps.
`default_nettype none

module register_chain
  import register_chain_pkg::*;
#(
  parameter int           N     = 4,
  parameter int           DEPTH = 4,
  parameter logic [N-1:0] INI   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [N-1:0]                din,
  output logic [N-1:0]                dout,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count
`ifdef REGISTER_CHAIN_TAPS_EN
  ,
  output logic [N*DEPTH-1:0]          taps
`endif
);

  localparam int            c_CW    = cnt_width(DEPTH);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic             w_load;
  logic             w_shift;
  logic             w_rotate;
  logic             w_clear;
  logic [N-1:0]     w_d [DEPTH];
  logic [N-1:0]     w_q [DEPTH];
  logic [c_CW-1:0]  r_count;

  always_comb begin
    w_shift  = 1'b0;
    w_rotate = 1'b0;
    w_clear  = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHIFT:  w_shift  = 1'b1;
        MODE_ROTATE: w_rotate = 1'b1;
        MODE_CLEAR:  w_clear  = 1'b1;
        default:     ;
      endcase
    end
  end

  assign w_load = w_shift | w_rotate | w_clear;

  // Stage 0 is fed from din on a shift and from the last stage on a rotate.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_d[k] = w_clear  ? INI :
                        w_rotate ? w_q[DEPTH-1] : din;
      end else begin : g_body
        assign w_d[k] = w_clear ? INI : w_q[k-1];
      end

      chain_stage #(
        .N   (N),
        .INI (INI)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_d    (w_d[k]),
        .o_q    (w_q[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_clear) begin
      r_count <= '0;
    end else if (w_shift && (r_count != c_DEPTH)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign dout  = w_q[DEPTH-1];
  assign count = r_count;
  assign full  = (r_count == c_DEPTH);

`ifdef REGISTER_CHAIN_TAPS_EN
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_taps
      assign taps[N*k +: N] = w_q[k];
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_chain.sv
// tb_register_chain: directed vectors for N=4, DEPTH=4, INI=4'hA; expected
// results are queued by the driver and checked by an independent monitor.
`default_nettype none

module tb_register_chain;
  import register_chain_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [1:0]   mode = MODE_HOLD;
  logic [N-1:0] din = '0;
  logic [N-1:0] dout;
  logic         full;
  logic [2:0]   count;
  logic [15:0]  taps_obs;

  typedef struct {
    logic [3:0]  d;
    logic [2:0]  c;
    logic        f;
    logic [15:0] t;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;
  bit   done     = 1'b0;

  always #5 clk = ~clk;

`ifdef REGISTER_CHAIN_TAPS_EN
  logic [N*DEPTH-1:0] taps;
  assign taps_obs = taps;
`else
  assign taps_obs = '0;
`endif

  register_chain #(
    .N     (N),
    .DEPTH (DEPTH),
    .INI   (4'hA)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .count (count)
`ifdef REGISTER_CHAIN_TAPS_EN
    ,
    .taps  (taps)
`endif
  );

  // Drive one cycle of inputs and queue what must be visible after that edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] d, input logic [3:0] ed,
                      input logic [2:0] ec, input logic ef, input logic [15:0] et);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    din  = d;
    step_id++;
    x.d = ed; x.c = ec; x.f = ef; x.t = et; x.id = step_id;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      n_checks++;
      if (dout !== x.d) begin
        n_fail++;
        $display("FAIL step %0d dout: got %h expected %h", x.id, dout, x.d);
      end
      n_checks++;
      if (count !== x.c) begin
        n_fail++;
        $display("FAIL step %0d count: got %0d expected %0d", x.id, count, x.c);
      end
      n_checks++;
      if (full !== x.f) begin
        n_fail++;
        $display("FAIL step %0d full: got %b expected %b", x.id, full, x.f);
      end
`ifdef REGISTER_CHAIN_TAPS_EN
      n_checks++;
      if (taps_obs !== x.t) begin
        n_fail++;
        $display("FAIL step %0d taps: got %h expected %h", x.id, taps_obs, x.t);
      end
`endif
    end
  end

  initial begin
    // reset held two cycles while en/mode request a shift
    step(0, 1, MODE_SHIFT,  4'hF, 4'hA, 3'd0, 0, 16'hAAAA);
    step(0, 1, MODE_SHIFT,  4'hF, 4'hA, 3'd0, 0, 16'hAAAA);
    // fill 1..4 then a saturating fifth shift
    step(1, 1, MODE_SHIFT,  4'h1, 4'hA, 3'd1, 0, 16'hAAA1);
    step(1, 1, MODE_SHIFT,  4'h2, 4'hA, 3'd2, 0, 16'hAA12);
    step(1, 1, MODE_SHIFT,  4'h3, 4'hA, 3'd3, 0, 16'hA123);
    step(1, 1, MODE_SHIFT,  4'h4, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 1, MODE_SHIFT,  4'h5, 4'h2, 3'd4, 1, 16'h2345);
    // clear from full, refill to 3, clear at count 3
    step(1, 1, MODE_CLEAR,  4'h9, 4'hA, 3'd0, 0, 16'hAAAA);
    step(1, 1, MODE_SHIFT,  4'h1, 4'hA, 3'd1, 0, 16'hAAA1);
    step(1, 1, MODE_SHIFT,  4'h2, 4'hA, 3'd2, 0, 16'hAA12);
    step(1, 1, MODE_SHIFT,  4'h3, 4'hA, 3'd3, 0, 16'hA123);
    step(1, 1, MODE_CLEAR,  4'h7, 4'hA, 3'd0, 0, 16'hAAAA);
    // rotate with a partial count keeps count
    step(1, 1, MODE_SHIFT,  4'h1, 4'hA, 3'd1, 0, 16'hAAA1);
    step(1, 1, MODE_ROTATE, 4'hF, 4'hA, 3'd1, 0, 16'hAA1A);
    step(1, 1, MODE_CLEAR,  4'h0, 4'hA, 3'd0, 0, 16'hAAAA);
    // build stages {4,3,2,1} and rotate four times
    step(1, 1, MODE_SHIFT,  4'h1, 4'hA, 3'd1, 0, 16'hAAA1);
    step(1, 1, MODE_SHIFT,  4'h2, 4'hA, 3'd2, 0, 16'hAA12);
    step(1, 1, MODE_SHIFT,  4'h3, 4'hA, 3'd3, 0, 16'hA123);
    step(1, 1, MODE_SHIFT,  4'h4, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 1, MODE_ROTATE, 4'hE, 4'h2, 3'd4, 1, 16'h2341);
    step(1, 1, MODE_ROTATE, 4'hE, 4'h3, 3'd4, 1, 16'h3412);
    step(1, 1, MODE_ROTATE, 4'hE, 4'h4, 3'd4, 1, 16'h4123);
    step(1, 1, MODE_ROTATE, 4'hE, 4'h1, 3'd4, 1, 16'h1234);
    // en low in shift, rotate and clear modes, then explicit hold
    step(1, 0, MODE_SHIFT,  4'h7, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 0, MODE_SHIFT,  4'h7, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 0, MODE_SHIFT,  4'h7, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 0, MODE_ROTATE, 4'h7, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 0, MODE_CLEAR,  4'h7, 4'h1, 3'd4, 1, 16'h1234);
    step(1, 1, MODE_HOLD,   4'h7, 4'h1, 3'd4, 1, 16'h1234);
    // reset mid-sequence beats an enabled shift
    step(0, 1, MODE_SHIFT,  4'h5, 4'hA, 3'd0, 0, 16'hAAAA);
    // first edge with rst high already operates
    step(1, 1, MODE_SHIFT,  4'h6, 4'hA, 3'd1, 0, 16'hAAA6);
    step(1, 1, MODE_HOLD,   4'h0, 4'hA, 3'd1, 0, 16'hAAA6);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    done = 1'b1;
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule

`default_nettype wire
